// File: rtl/fixed_point_multiplier_pkg.sv
// rtl/fixed_point_multiplier_pkg.sv - widths, saturation limits and clamp helper for the pixel*weight multiplier
package fixed_point_multiplier_pkg;

  localparam int W_WIDTH    = 19;
  localparam int P_WIDTH    = 10;
  localparam int OUT_WIDTH  = 26;
  localparam int PROD_WIDTH = W_WIDTH + P_WIDTH;

  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // In range exactly when every bit above the output sign bit matches it.
  function automatic logic signed [OUT_WIDTH-1:0] saturate(
    input logic signed [PROD_WIDTH-1:0] prod
  );
    logic [PROD_WIDTH-OUT_WIDTH:0] hi;
    hi = prod[PROD_WIDTH-1:OUT_WIDTH-1];
    if ((&hi) || !(|hi)) begin
      saturate = prod[OUT_WIDTH-1:0];
    end else if (prod[PROD_WIDTH-1]) begin
      saturate = OUT_MIN;
    end else begin
      saturate = OUT_MAX;
    end
  endfunction

endpackage

// File: rtl/fixed_point_multiplier_if.sv
// rtl/fixed_point_multiplier_if.sv - operand and result bundle for the multiplier
interface fixed_point_multiplier_if;
  import fixed_point_multiplier_pkg::*;

  logic signed [W_WIDTH-1:0]   WeightPort;
  logic        [P_WIDTH-1:0]   PixelPort;
  logic signed [OUT_WIDTH-1:0] Output_syn;

  modport master (output WeightPort, output PixelPort, input Output_syn);
  modport slave  (input WeightPort, input PixelPort, output Output_syn);

endinterface

// File: rtl/fixed_point_mult_core.sv
// rtl/fixed_point_mult_core.sv - combinational signed x unsigned array multiplier, exact 29-bit product
module fixed_point_mult_core
  import fixed_point_multiplier_pkg::*;
(
  input  logic signed [W_WIDTH-1:0]    i_weight,
  input  logic        [P_WIDTH-1:0]    i_pixel,
  output logic signed [PROD_WIDTH-1:0] o_product
);

  localparam int N_LEAF = 16;

  logic signed [PROD_WIDTH-1:0] w_pp [N_LEAF];
  logic signed [PROD_WIDTH-1:0] w_l1 [8];
  logic signed [PROD_WIDTH-1:0] w_l2 [4];
  logic signed [PROD_WIDTH-1:0] w_l3 [2];

  // Pixel is unsigned, so each set bit contributes the sign-extended weight shifted into place.
  always_comb begin
    for (int i = 0; i < N_LEAF; i++) begin
      w_pp[i] = '0;
    end
    for (int i = 0; i < P_WIDTH; i++) begin
      if (i_pixel[i]) begin
        w_pp[i] = PROD_WIDTH'(i_weight) <<< i;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      w_l1[i] = w_pp[2*i] + w_pp[2*i+1];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
    end
  end

  assign o_product = w_l3[0] + w_l3[1];

endmodule

// File: rtl/fixed_point_multiplier.sv
// rtl/fixed_point_multiplier.sv - two-stage pipelined saturating pixel*weight multiplier
module fixed_point_multiplier
  import fixed_point_multiplier_pkg::*;
(
  input logic                      clk,
  input logic                      GlobalReset,
  fixed_point_multiplier_if.slave  bus
);

  logic signed [W_WIDTH-1:0]    r_weight;
  logic        [P_WIDTH-1:0]    r_pixel;
  logic signed [OUT_WIDTH-1:0]  r_out;
  logic signed [PROD_WIDTH-1:0] w_product;

  fixed_point_mult_core u_core (
    .i_weight  (r_weight),
    .i_pixel   (r_pixel),
    .o_product (w_product)
  );

  // Clearing both stages on reset guarantees no pre-reset product can surface later.
  always_ff @(posedge clk) begin
    if (!GlobalReset) begin
      r_weight <= '0;
      r_pixel  <= '0;
      r_out    <= '0;
    end else begin
      r_weight <= bus.WeightPort;
      r_pixel  <= bus.PixelPort;
      r_out    <= saturate(w_product);
    end
  end

  assign bus.Output_syn = r_out;

endmodule

// File: tb/tb_fixed_point_multiplier.sv
// tb/tb_fixed_point_multiplier.sv - directed self-checking bench for fixed_point_multiplier
module tb_fixed_point_multiplier;
  import fixed_point_multiplier_pkg::*;

  logic clk;
  logic GlobalReset;
  int   checks;
  int   errors;

  fixed_point_multiplier_if bus ();

  fixed_point_multiplier dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  task automatic check(input string tag, input logic [OUT_WIDTH-1:0] expected);
    logic [OUT_WIDTH-1:0] observed;
    observed = bus.Output_syn;
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [W_WIDTH-1:0] w, input logic [P_WIDTH-1:0] p);
    bus.WeightPort = w;
    bus.PixelPort  = p;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    GlobalReset = 1'b0;
    drive(19'd0, 10'd0);

    tick(1);
    check("reset", 26'h0000000);

    GlobalReset = 1'b1;
    drive(19'h7FFFD, 10'd222);
    tick(1);
    check("post_reset_fill", 26'h0000000);
    tick(1);
    check("neg_weight", 26'h3FFFD66);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("neg_weight_hold", 26'h3FFFD66);
    end

    drive(19'h7FFFF, 10'd198);
    tick(2);
    check("weight_minus1", 26'h3FFFF3A);

    drive(19'd50, 10'd8);
    tick(1);
    drive(19'd100, 10'd20);
    tick(1);
    check("b2b_first", 26'd400);
    tick(1);
    check("b2b_second", 26'd2000);

    drive(19'h3FFFF, 10'd1023);
    tick(2);
    check("sat_pos", 26'h1FFFFFF);

    drive(19'h40000, 10'd1023);
    tick(2);
    check("sat_neg", 26'h2000000);

    drive(19'd32767, 10'd1023);
    tick(2);
    check("in_range_large", 26'h1FF7C01);

    drive(19'h40000, 10'd0);
    tick(2);
    check("pixel_zero", 26'h0000000);

    drive(19'd0, 10'd1023);
    tick(2);
    check("weight_zero", 26'h0000000);

    drive(19'h7FFFF, 10'd1023);
    tick(2);
    check("minus1_max_pixel", 26'h3FFFC01);

    drive(19'd100, 10'd20);
    tick(1);
    GlobalReset = 1'b0;
    drive(19'd0, 10'd0);
    tick(1);
    check("midpipe_reset", 26'h0000000);
    GlobalReset = 1'b1;
    tick(1);
    check("midpipe_flush1", 26'h0000000);
    tick(1);
    check("midpipe_flush2", 26'h0000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
